z80_bus_arbiter: RTL
====================

Z80_BUS_ARBITER -- requirements
Module: z80_bus_arbiter

Interface
REQ-001 Parameter: MAX_HOLD, 64, maximum DMA tenure in cen-qualified cycles, legal range 1..256.
REQ-002 Parameter: WAIT_CYCLES, 2, wait states inserted per slow CPU access, legal range 0..15.
REQ-003 clk  input  1  clock; all state updates on posedge clk.
REQ-004 reset_n  input  1  reset; asynchronous, active-low.
REQ-005 cen  input  1  clock enable shared with the CPU core; state advances only when cen=1.
REQ-006 dma_req  input  1  DMA requester wants the bus; level.
REQ-007 dma_done  input  1  requester finished; sampled only in GRANT.
REQ-008 dma_gnt  output  1  requester owns the bus.
REQ-009 busrq_n  output  1  to CPU busrq_n.
REQ-010 busak_n  input  1  from CPU busak_n.
REQ-011 bus_sel  output  1  bus mux select; 0 = CPU, 1 = DMA.
REQ-012 mreq_n, rd_n, wr_n  input  1 each  CPU strobes.
REQ-013 slow  input  1  address decode; the current CPU access targets a slow device.
REQ-014 wait_n  output  1  to CPU wait_n.
REQ-015 timeout  output  1  one-cen-cycle pulse when a grant is revoked at MAX_HOLD.

Function
REQ-016 All outputs SHALL be registered; every transition below occurs on a posedge clk with cen=1, and the block SHALL hold all state when cen=0.
REQ-017 FSM states SHALL be IDLE, REQ, GRANT, RELEASE and HOLDOFF.
REQ-018 IDLE: busrq_n=1, dma_gnt=0, bus_sel=0; if dma_req=1 and the FSM has spent at least one cycle in IDLE -> REQ.
REQ-019 REQ: busrq_n=0; busak_n=0 -> GRANT; dma_req=0 before busak_n=0 -> IDLE (request withdrawn, busrq_n=1).
REQ-020 GRANT: busrq_n=0, bus_sel=1, dma_gnt=1; the 8-bit hold counter SHALL clear on entry and increment each cycle.
REQ-021 GRANT exit: dma_done=1 or dma_req=0 -> RELEASE; otherwise a counter value of MAX_HOLD-1 -> RELEASE with timeout=1 for exactly one cen cycle.
REQ-022 If dma_done=1 and the counter reaches MAX_HOLD-1 in the same cycle, done SHALL win and timeout SHALL remain 0.
REQ-023 RELEASE: dma_gnt=0, busrq_n=1, bus_sel=1 held for exactly one cycle (turnaround) -> HOLDOFF.
REQ-024 HOLDOFF: bus_sel=0, busrq_n=1; busak_n=1 -> IDLE; dma_req SHALL be ignored until the FSM is back in IDLE.
REQ-025 The IDLE minimum-stay rule guarantees at least one CPU-owned cycle between consecutive grants.
REQ-026 Wait generator arms when bus_sel=0, mreq_n=0, (rd_n=0 or wr_n=0) and slow=1 are first seen together; it SHALL then drive wait_n=0 for exactly WAIT_CYCLES cycles starting the next cycle, then wait_n=1.
REQ-027 The wait generator SHALL NOT re-arm until mreq_n has returned to 1; WAIT_CYCLES=0 SHALL keep wait_n=1 permanently.
REQ-028 wait_n SHALL be 1 whenever bus_sel=1; entering GRANT SHALL abort any in-progress wait count.
REQ-029 busak_n returning to 1 while in GRANT (protocol error) SHALL force RELEASE with no timeout pulse.

Reset
REQ-030 While reset_n=0: FSM=IDLE, busrq_n=1, dma_gnt=0, bus_sel=0, wait_n=1, timeout=0, hold and wait counters=0, wait generator disarmed.
REQ-031 Reset asserted mid-GRANT SHALL drive the REQ-030 values immediately (asynchronously), without passing through RELEASE.

Verification
REQ-032 dma_req=1 at cycle 0, busak_n falls at cycle 3, dma_done pulses at cycle 10 -> busrq_n=0 from cycle 1; dma_gnt/bus_sel=1 from cycle 4; dma_gnt=0 at cycle 11; bus_sel=0 at cycle 12; timeout never asserted.
REQ-033 MAX_HOLD=4, dma_req held high, busak_n=0 -> dma_gnt high for exactly 4 cycles, a single timeout pulse on the RELEASE cycle, then re-grant only after a HOLDOFF cycle and at least one IDLE cycle.
REQ-034 WAIT_CYCLES=2, slow read with mreq_n low for 6 cycles -> wait_n low for exactly 2 cycles after arming, with no second assertion before mreq_n rises.
REQ-035 dma_req dropped while in REQ before busak_n -> busrq_n returns to 1 on the next cycle and dma_gnt never asserts.
REQ-036 reset_n pulsed low mid-GRANT with cen=0 -> busrq_n=1, bus_sel=0, dma_gnt=0 immediately; the FSM is in IDLE after reset releases.
REQ-037 Toggle cen at a 1/3 duty cycle across REQ-032 -> identical sequence, measured in cen-qualified cycles.

Source files
------------

// File: rtl/z80_bus_arbiter.sv
// Hands the Z80 bus to a DMA requester through BUSRQ/BUSAK, with a bounded
// tenure, a one-cycle mux turnaround, and a wait-state generator for slow devices.
module z80_bus_arbiter #(
  parameter int MAX_HOLD    = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic cen,
  input  logic dma_req,
  input  logic dma_done,
  output logic dma_gnt,
  output logic busrq_n,
  input  logic busak_n,
  output logic bus_sel,
  input  logic mreq_n,
  input  logic rd_n,
  input  logic wr_n,
  input  logic slow,
  output logic wait_n,
  output logic timeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_GRANT,
    S_RELEASE,
    S_HOLDOFF
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  state_t     state_q, state_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic       armed_q, armed_d;
  logic       dma_gnt_q, dma_gnt_d;
  logic       busrq_n_q, busrq_n_d;
  logic       bus_sel_q, bus_sel_d;
  logic       wait_n_q, wait_n_d;
  logic       timeout_q, timeout_d;
  logic       slow_access;

  // Outputs are decoded from the next state so they line up with the state register.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    timeout_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (dma_req) state_d = S_REQ;
      end
      S_REQ: begin
        if (!busak_n) begin
          state_d    = S_GRANT;
          hold_cnt_d = '0;
        end else if (!dma_req) begin
          state_d = S_IDLE;
        end
      end
      S_GRANT: begin
        // A lost BUSAK, a finished requester or a withdrawn request all beat the tenure limit.
        if (busak_n || dma_done || !dma_req) begin
          state_d = S_RELEASE;
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d   = S_RELEASE;
          timeout_d = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      S_RELEASE: begin
        state_d = S_HOLDOFF;
      end
      S_HOLDOFF: begin
        if (busak_n) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    dma_gnt_d = (state_d == S_GRANT);
    busrq_n_d = !((state_d == S_REQ) || (state_d == S_GRANT));
    bus_sel_d = (state_d == S_GRANT) || (state_d == S_RELEASE);
  end

  assign slow_access = !bus_sel_q && !mreq_n && (!rd_n || !wr_n) && slow;

  // One wait burst per MREQ assertion; the mux swinging to DMA cancels it.
  always_comb begin
    armed_d    = mreq_n ? 1'b0 : (armed_q || slow_access);
    wait_cnt_d = wait_cnt_q;
    if (bus_sel_d) begin
      wait_cnt_d = '0;
    end else if (slow_access && !armed_q) begin
      wait_cnt_d = WAIT_LOAD;
    end else if (wait_cnt_q != 4'd0) begin
      wait_cnt_d = wait_cnt_q - 4'd1;
    end
    wait_n_d = (wait_cnt_d == 4'd0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      hold_cnt_q <= '0;
      wait_cnt_q <= '0;
      armed_q    <= 1'b0;
      dma_gnt_q  <= 1'b0;
      busrq_n_q  <= 1'b1;
      bus_sel_q  <= 1'b0;
      wait_n_q   <= 1'b1;
      timeout_q  <= 1'b0;
    end else if (cen) begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      armed_q    <= armed_d;
      dma_gnt_q  <= dma_gnt_d;
      busrq_n_q  <= busrq_n_d;
      bus_sel_q  <= bus_sel_d;
      wait_n_q   <= wait_n_d;
      timeout_q  <= timeout_d;
    end
  end

  assign dma_gnt = dma_gnt_q;
  assign busrq_n = busrq_n_q;
  assign bus_sel = bus_sel_q;
  assign wait_n  = wait_n_q;
  assign timeout = timeout_q;

endmodule
